// File: rtl/mlp_frame_loader.sv
// Sample-to-feature front end for the combinational MLP core: quantizes and packs a frame,
// holds it for a settle window, then captures and presents the class index on a valid/ready port.
//
// state  | meaning
// LOAD   | accepting samples into staging slots (s_ready=1)
// SETTLE | inp held stable while the classifier resolves
// OUT    | captured class presented until m_ready
module mlp_frame_loader #(
  parameter int N_FEAT   = 6,
  parameter int FEAT_W   = 5,
  parameter int SAMPLE_W = 8,
  parameter int SHIFT    = 2,
  parameter int SETTLE   = 2,
  parameter int CLS_W    = 2,
  parameter int CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [SAMPLE_W-1:0]        s_data,
  input  logic                       s_last,
  output logic [N_FEAT*FEAT_W-1:0]   inp,
  input  logic [CLS_W-1:0]           cls_in,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [CLS_W-1:0]           m_class,
  output logic                       err_frame,
  output logic [CNT_W-1:0]           frame_cnt
);

  localparam int IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_FEAT - 1);
  localparam logic [SET_W-1:0]    SET_LAST = SET_W'(SETTLE - 1);
  localparam logic [SAMPLE_W-1:0] Q_MAX    = SAMPLE_W'((1 << FEAT_W) - 1);

  typedef enum logic [1:0] {ST_LOAD, ST_SETTLE, ST_OUT} state_t;

  state_t state, state_nxt;

  logic [IDX_W-1:0]          idx;
  logic [SET_W-1:0]          cnt;
  logic [FEAT_W-1:0]         stage [N_FEAT];
  logic [SAMPLE_W-1:0]       q_raw;
  logic [FEAT_W-1:0]         q;
  logic [N_FEAT*FEAT_W-1:0]  frame_vec;
  logic                      at_last;
  logic                      accept;
  logic                      frame_done;
  logic                      frame_bad;
  logic                      capture;

  assign q_raw   = s_data >> SHIFT;
  assign q       = (q_raw > Q_MAX) ? Q_MAX[FEAT_W-1:0] : q_raw[FEAT_W-1:0];
  assign at_last = (idx == IDX_LAST);

  // Final sample bypasses staging so inp is loaded on the same edge it is accepted.
  always_comb begin
    frame_vec = '0;
    for (int k = 0; k < N_FEAT; k++) begin
      frame_vec[k*FEAT_W +: FEAT_W] = stage[k];
    end
    frame_vec[(N_FEAT-1)*FEAT_W +: FEAT_W] = q;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    s_ready    = 1'b0;
    accept     = 1'b0;
    frame_done = 1'b0;
    frame_bad  = 1'b0;
    capture    = 1'b0;
    case (state)
      ST_LOAD: begin
        s_ready = 1'b1;
        accept  = s_valid;
        if (accept) begin
          if (at_last && s_last) begin
            frame_done = 1'b1;
            state_nxt  = ST_SETTLE;
          end else if (at_last != s_last) begin
            frame_bad = 1'b1;
          end
        end
      end
      ST_SETTLE: begin
        if (cnt == SET_LAST) begin
          capture   = 1'b1;
          state_nxt = ST_OUT;
        end
      end
      ST_OUT: begin
        if (m_ready) state_nxt = ST_LOAD;
      end
      default: state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      cnt       <= '0;
      inp       <= '0;
      m_valid   <= 1'b0;
      m_class   <= '0;
      err_frame <= 1'b0;
      frame_cnt <= '0;
      for (int k = 0; k < N_FEAT; k++) stage[k] <= '0;
    end else begin
      err_frame <= frame_bad;
      if (accept) begin
        if (frame_done || frame_bad) begin
          idx <= '0;
        end else begin
          stage[idx] <= q;
          idx        <= idx + 1'b1;
        end
      end
      if (frame_done) begin
        stage[IDX_LAST] <= q;
        inp             <= frame_vec;
        frame_cnt       <= frame_cnt + 1'b1;
        cnt             <= '0;
      end
      if (state == ST_SETTLE) cnt <= cnt + 1'b1;
      if (capture) begin
        m_class <= cls_in;
        m_valid <= 1'b1;
      end else if (state == ST_OUT && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule
